// File: rtl/fa_sched_pkg.sv
// Shared types for the bit-serial add scheduler and its configurable adder cell.
//   approx_mode_e : sum rule applied to approximate bit positions
//   sched_state_e : scheduler FSM states
package fa_sched_pkg;

  typedef enum logic [1:0] {AM_EXACT, AM_XOR, AM_ORAND, AM_PASSB} approx_mode_e;

  typedef enum {IDLE, RUN, DONE} sched_state_e;

endpackage

// File: rtl/fa_cell_cfg.sv
// Single-bit full-adder cell with a selectable sum rule.
//   a, b, cin : operand bits and carry in
//   mode_sel  : sum rule (exact, a^b, (~a|b)&cin, b)
//   s         : sum bit produced by the selected rule
//   cout      : carry out, always the exact full-adder carry
module fa_cell_cfg
  import fa_sched_pkg::*;
(
  input  logic         a,
  input  logic         b,
  input  logic         cin,
  input  approx_mode_e mode_sel,
  output logic         s,
  output logic         cout
);

  always_comb begin
    // Carry stays exact so approximation error never propagates upward.
    cout = (a & b) | ((a ^ b) & cin);
    s    = a ^ b ^ cin;
    case (mode_sel)
      AM_XOR:   s = a ^ b;
      AM_ORAND: s = (~a | b) & cin;
      AM_PASSB: s = b;
      default:  s = a ^ b ^ cin;
    endcase
  end

endmodule

// File: rtl/fa_serial_sched.sv
// Bit-serial add scheduler: runs one shared full-adder cell over WIDTH bits,
// LSB first, one bit per clock. The lowest k bits use a selectable
// approximate sum rule, upper bits the exact rule.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand pair handshake
//   a, b                  : operands
//   approx_lsbs           : number of approximate LSB positions (clamped to WIDTH)
//   approx_mode           : sum rule for approximate positions
//   out_valid / out_ready : result handshake
//   sum, cout             : result and final carry
//   busy                  : high while computing or holding a result
//   ops_done              : saturating count of delivered results
module fa_serial_sched
  import fa_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [$clog2(WIDTH+1)-1:0]   approx_lsbs,
  input  logic [1:0]                   approx_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             sum,
  output logic                         cout,
  output logic                         busy,
  output logic [CNT_W-1:0]             ops_done
);

  localparam int K_W   = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [K_W-1:0]   WIDTH_K  = K_W'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [K_W-1:0]     r_k;
  approx_mode_e       r_mode;
  logic [CNT_W-1:0]   r_ops;

  logic               w_accept;
  logic               w_last;
  logic [K_W-1:0]     w_k_clamp;
  approx_mode_e       w_bit_mode;
  logic               w_s;
  logic               w_c;

  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_k_clamp  = (approx_lsbs > WIDTH_K) ? WIDTH_K : approx_lsbs;
  assign w_bit_mode = (K_W'(r_idx) < r_k) ? r_mode : AM_EXACT;

  // Operands are shifted right each bit, so the cell always sees bit 0.
  fa_cell_cfg u_cell (
    .a        (r_a[0]),
    .b        (r_b[0]),
    .cin      (r_carry),
    .mode_sel (w_bit_mode),
    .s        (w_s),
    .cout     (w_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input-to-output comb path.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == RUN) || (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_k     <= '0;
      r_mode  <= AM_EXACT;
      r_ops   <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_k     <= w_k_clamp;
        r_mode  <= approx_mode_e'(approx_mode);
        r_carry <= 1'b0;
        r_idx   <= '0;
      end
      if (r_state == RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        // Sum bits enter at the MSB; after WIDTH shifts bit i sits at sum[i].
        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
        r_carry <= w_c;
        if (w_last) begin
          r_cout <= w_c;
          r_idx  <= '0;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end
      if ((r_state == DONE) && out_ready && (r_ops != {CNT_W{1'b1}})) begin
        r_ops <= r_ops + 1'b1;
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign ops_done = r_ops;

endmodule
